// File: rtl/tqvp_gera_gray_pkg.sv
// Shared definitions for the Gray encoder receiver: register map, FSM encoding,
// STATUS bit positions and a Gray-to-binary helper reusable by the coder peripheral.
package tqvp_gera_gray_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_POS    = 4'h1;
  localparam logic [3:0] ADDR_RAW    = 4'h2;
  localparam logic [3:0] ADDR_ACC_L  = 4'h3;
  localparam logic [3:0] ADDR_ACC_H  = 4'h4;
  localparam logic [3:0] ADDR_ERRCNT = 4'h5;
  localparam logic [3:0] ADDR_DEBTHR = 4'h6;
  localparam logic [3:0] ADDR_IRQEN  = 4'h7;

  typedef logic [1:0] state_t;
  localparam state_t ST_INIT   = 2'd0;
  localparam state_t ST_STABLE = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

  localparam int unsigned STATUS_NEW = 0;
  localparam int unsigned STATUS_ERR = 1;
  localparam int unsigned STATUS_DIR = 2;

  // Any width up to 8 works: zero-extend the code and slice the low bits of the result.
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/tqvp_gera_gray_encoder_rx_if.sv
// TinyQV peripheral register bus: 4-bit address, 8-bit write data, combinational read data.
interface tqvp_gera_gray_encoder_rx_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_gera_gray_debounce.sv
// Qualifies a sampled Gray code: a candidate held for thr+1 further cycles produces a
// single-cycle commit pulse. The first code after reset always passes through SETTLE.
module tqvp_gera_gray_debounce
  import tqvp_gera_gray_pkg::*;
#(
  parameter int unsigned GRAY_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GRAY_W-1:0] i_sample,
  input  logic [7:0]        i_thr,
  output logic              o_commit,
  output logic [GRAY_W-1:0] o_cand
);

  state_t            r_state, w_state_d;
  logic [GRAY_W-1:0] r_cand, w_cand_d;
  logic [7:0]        r_cnt, w_cnt_d;

  always_comb begin
    w_state_d = r_state;
    w_cand_d  = r_cand;
    w_cnt_d   = r_cnt;
    o_commit  = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_cand_d  = i_sample;
        w_cnt_d   = 8'd0;
        w_state_d = ST_SETTLE;
      end
      ST_STABLE: begin
        if (i_sample != r_cand) begin
          w_cand_d  = i_sample;
          w_cnt_d   = 8'd0;
          w_state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (i_sample != r_cand) begin
          w_cand_d = i_sample;
          w_cnt_d  = 8'd0;
        end else if (r_cnt >= i_thr) begin
          // >= so that lowering the threshold below cnt commits at once
          o_commit  = 1'b1;
          w_state_d = ST_STABLE;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      default: w_state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cand  <= '0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_d;
      r_cand  <= w_cand_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign o_cand = r_cand;

endmodule

// File: rtl/tqvp_gera_gray_encoder_rx.sv
// Gray rotary encoder receiver: debounce, Gray-to-binary, step tracking into a 16-bit
// accumulator, illegal-jump flagging. Optional IRQ output enabled by GRAY_RX_IRQ_EN.
module tqvp_gera_gray_encoder_rx
  import tqvp_gera_gray_pkg::*;
#(
  parameter int unsigned GRAY_W       = 4,
  parameter logic [7:0]  DEBOUNCE_RST = 8'd16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 ui_in,
  output logic [7:0]                 uo_out,
  tqvp_gera_gray_encoder_rx_if.slave bus
`ifdef GRAY_RX_IRQ_EN
  ,
  output logic                       user_interrupt
`endif
);

  logic              w_commit;
  logic [GRAY_W-1:0] w_cand;
  logic [7:0]        w_bin_full;
  logic [GRAY_W-1:0] w_bin, w_delta;
  logic              w_step, w_up, w_dn, w_bad;
  logic              w_wr_status, w_wr_acc, w_wr_errcnt, w_wr_debthr, w_rd_acc_l;
  logic [7:0]        w_status, w_data_out;

  logic [GRAY_W-1:0] r_ref_bin;
  logic              r_primed;
  logic [15:0]       r_acc;
  logic [7:0]        r_acc_h_shadow, r_err_cnt, r_deb_thr;
  logic              r_dir, r_err, r_new;

  tqvp_gera_gray_debounce #(.GRAY_W(GRAY_W)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .i_sample (ui_in[GRAY_W-1:0]),
    .i_thr    (r_deb_thr),
    .o_commit (w_commit),
    .o_cand   (w_cand)
  );

  assign w_bin_full = gray2bin(8'(w_cand));
  assign w_bin      = w_bin_full[GRAY_W-1:0];
  assign w_delta    = w_bin - r_ref_bin;
  // The first commit after reset only establishes the reference position.
  assign w_step     = w_commit & r_primed;
  assign w_up       = w_step && (w_delta == GRAY_W'(1));
  assign w_dn       = w_step && (w_delta == '1);
  assign w_bad      = w_step && (w_delta != '0) && !w_up && !w_dn;

  assign w_wr_status = bus.data_write && (bus.address == ADDR_STATUS);
  assign w_wr_acc    = bus.data_write && (bus.address == ADDR_ACC_L);
  assign w_wr_errcnt = bus.data_write && (bus.address == ADDR_ERRCNT);
  assign w_wr_debthr = bus.data_write && (bus.address == ADDR_DEBTHR);
  assign w_rd_acc_l  = !bus.data_write && (bus.address == ADDR_ACC_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_bin      <= '0;
      r_primed       <= 1'b0;
      r_acc          <= 16'd0;
      r_acc_h_shadow <= 8'd0;
      r_err_cnt      <= 8'd0;
      r_deb_thr      <= DEBOUNCE_RST;
      r_dir          <= 1'b0;
      r_err          <= 1'b0;
      r_new          <= 1'b0;
    end else begin
      if (w_commit) begin
        r_ref_bin <= w_bin;
        r_primed  <= 1'b1;
      end
      if (w_up || w_dn) r_dir <= w_up;
      if (w_up || w_dn) r_new <= 1'b1;
      else if (w_wr_status && bus.data_in[STATUS_NEW]) r_new <= 1'b0;
      if (w_bad) r_err <= 1'b1;
      else if (w_wr_status && bus.data_in[STATUS_ERR]) r_err <= 1'b0;
      if (w_wr_acc) r_acc <= 16'd0;
      else if (w_up) r_acc <= r_acc + 16'd1;
      else if (w_dn) r_acc <= r_acc - 16'd1;
      if (w_wr_errcnt) r_err_cnt <= 8'd0;
      else if (w_bad && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_rd_acc_l) r_acc_h_shadow <= r_acc[15:8];
      if (w_wr_debthr) r_deb_thr <= bus.data_in;
    end
  end

`ifdef GRAY_RX_IRQ_EN
  logic [1:0] r_ie;
  logic       r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie  <= 2'b00;
      r_irq <= 1'b0;
    end else begin
      if (bus.data_write && (bus.address == ADDR_IRQEN)) r_ie <= bus.data_in[1:0];
      r_irq <= (r_new & r_ie[0]) | (r_err & r_ie[1]);
    end
  end

  assign user_interrupt = r_irq;
`endif

  always_comb begin
    w_status             = 8'd0;
    w_status[STATUS_NEW] = r_new;
    w_status[STATUS_ERR] = r_err;
    w_status[STATUS_DIR] = r_dir;
  end

  always_comb begin
    w_data_out = 8'd0;
    case (bus.address)
      ADDR_STATUS: w_data_out = w_status;
      ADDR_POS:    w_data_out = 8'(r_ref_bin);
      ADDR_RAW:    w_data_out = 8'(w_cand);
      ADDR_ACC_L:  w_data_out = r_acc[7:0];
      ADDR_ACC_H:  w_data_out = r_acc_h_shadow;
      ADDR_ERRCNT: w_data_out = r_err_cnt;
      ADDR_DEBTHR: w_data_out = r_deb_thr;
`ifdef GRAY_RX_IRQ_EN
      ADDR_IRQEN:  w_data_out = {6'd0, r_ie};
`endif
      default:     w_data_out = 8'd0;
    endcase
  end

  assign bus.data_out = w_data_out;

  if (GRAY_W <= 4) begin : g_uo_flags
    assign uo_out = {r_dir, r_err, r_new, 1'b0, 4'(r_ref_bin)};
  end else begin : g_uo_wide
    assign uo_out = 8'(r_ref_bin);
  end

  logic w_unused;
  assign w_unused = &{1'b0, ui_in[7:GRAY_W], w_bin_full[7:GRAY_W]};

endmodule
